// File: rtl/icache_fill_unit_pkg.sv
// Shared constants, state encoding and helpers for the instruction cache fill unit.
// Address layout (word address): {tag, index, offset}.
package icache_fill_unit_pkg;

  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned NUM_LINES  = 8;
  localparam int unsigned CNT_W      = 16;

  localparam int unsigned OFFSET_W = $clog2(LINE_WORDS);
  localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W    = WORD_SIZE - INDEX_W - OFFSET_W;

  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } state_e;

  // Saturating increment for the debug counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/icache_tag_data_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset (clears valid bits)
//   rd_index_i/rd_offset_i -> rd_word_o, rd_tag_o, rd_valid_o  combinational read port
//   wr_en_i, wr_index_i, wr_offset_i, wr_data_i  synchronous word write
//   commit_i, commit_tag_i  set tag and valid of line wr_index_i
//   clear_i           clear every valid bit (wins over commit)
module icache_tag_data_array
  import icache_fill_unit_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INDEX_W-1:0]   rd_index_i,
  input  logic [OFFSET_W-1:0]  rd_offset_i,
  output logic [WORD_SIZE-1:0] rd_word_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic                 rd_valid_o,
  input  logic                 wr_en_i,
  input  logic [INDEX_W-1:0]   wr_index_i,
  input  logic [OFFSET_W-1:0]  wr_offset_i,
  input  logic [WORD_SIZE-1:0] wr_data_i,
  input  logic                 commit_i,
  input  logic [TAG_W-1:0]     commit_tag_i,
  input  logic                 clear_i
);

  logic [WORD_SIZE-1:0] data_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  // Data and tags need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_index_i][wr_offset_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit_i) begin
      tag_q[wr_index_i] <= commit_tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q <= '0;
    end else if (commit_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  assign rd_word_o  = data_q[rd_index_i][rd_offset_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

endmodule

// File: rtl/icache_fill_unit.sv
// Direct-mapped instruction cache with a word-serial line fill from instruction memory.
// Hits are served combinationally; a miss stalls the IF stage (cpu_ready=0) while the
// whole line is fetched, after which the same address hits.
// Ports:
//   clk, reset (sync, active-high)
//   cpu_read, cpu_address -> cpu_data, cpu_ready   IF-side lookup
//   invalidate                                     clear all lines, abort any fill
//   mem_read, mem_address <- mem_rdata, mem_valid  line-fill interface
//   hit_count, miss_count                          saturating debug counters
module icache_fill_unit
  import icache_fill_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_read,
  input  logic [WORD_SIZE-1:0] cpu_address,
  output logic [WORD_SIZE-1:0] cpu_data,
  output logic                 cpu_ready,
  input  logic                 invalidate,
  output logic                 mem_read,
  output logic [WORD_SIZE-1:0] mem_address,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_valid,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count
);

  state_e               state_q, state_d;
  logic [OFFSET_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]   miss_index_q, miss_index_d;
  logic [CNT_W-1:0]     hit_count_q, hit_count_d;
  logic [CNT_W-1:0]     miss_count_q, miss_count_d;

  logic [TAG_W-1:0]     cpu_tag;
  logic [INDEX_W-1:0]   cpu_index;
  logic [OFFSET_W-1:0]  cpu_offset;
  logic [WORD_SIZE-1:0] rd_word;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_valid;
  logic                 hit, miss, fill_wr, fill_last;

  assign {cpu_tag, cpu_index, cpu_offset} = cpu_address;

  icache_tag_data_array u_array (
    .clk_i        (clk),
    .rst_i        (reset),
    .rd_index_i   (cpu_index),
    .rd_offset_i  (cpu_offset),
    .rd_word_o    (rd_word),
    .rd_tag_o     (rd_tag),
    .rd_valid_o   (rd_valid),
    .wr_en_i      (fill_wr),
    .wr_index_i   (miss_index_q),
    .wr_offset_i  (cnt_q),
    .wr_data_i    (mem_rdata),
    .commit_i     (fill_last),
    .commit_tag_i (miss_tag_q),
    .clear_i      (invalidate)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    hit          = 1'b0;
    miss         = 1'b0;
    fill_wr      = 1'b0;
    fill_last    = 1'b0;

    unique case (state_q)
      StIdle: begin
        hit = cpu_read && rd_valid && (rd_tag == cpu_tag) && !invalidate && !reset;
        if (cpu_read && !hit && !invalidate) begin
          miss         = 1'b1;
          state_d      = StFill;
          miss_tag_d   = cpu_tag;
          miss_index_d = cpu_index;
          cnt_d        = '0;
        end
      end
      StFill: begin
        // An invalidate in the same cycle aborts the fill; nothing may be committed.
        if (mem_valid && !invalidate) begin
          fill_wr = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (&cnt_q) begin
            fill_last = 1'b1;
            state_d   = StIdle;
          end
        end
      end
    endcase

    if (invalidate) begin
      state_d = StIdle;
    end
    if (hit) begin
      hit_count_d = sat_inc(hit_count_q);
    end
    if (miss) begin
      miss_count_d = sat_inc(miss_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign cpu_ready   = hit;
  assign cpu_data    = hit ? rd_word : '0;
  assign mem_read    = (state_q == StFill) && !reset;
  assign mem_address = mem_read ? {miss_tag_q, miss_index_q, cnt_q} : '0;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

endmodule

// File: doc/icache_fill_unit.md
Name: icache_fill_unit

Overview:
- Direct-mapped instruction cache between the pipelined datapath's IF port and instruction memory.
- Serves hits in the same cycle the address is presented.
- On a miss, deasserts cpu_ready so the IF stage holds its PC, fetches the whole line word by word from memory, then resumes with a hit.
- Exports hit/miss counters for debug alongside num_inst.

Parameters:
WORD_SIZE, 16, address and data width
LINE_WORDS, 4, words per line (power of 2)
NUM_LINES, 8, lines in cache (power of 2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
cpu_read  input  1  IF stage requests instruction at cpu_address
cpu_address  input  16  word address from IF pc
cpu_data  output  16  instruction word; valid when cpu_ready=1
cpu_ready  output  1  combinational hit indication; 0 = IF must stall
invalidate  input  1  clear all valid bits
mem_read  output  1  line-fill request to instruction memory
mem_address  output  16  word address of the fill word currently requested
mem_rdata  input  16  memory read data
mem_valid  input  1  mem_rdata holds the word at mem_address this cycle
hit_count  output  16  saturating count of hit cycles
miss_count  output  16  saturating count of misses

Behaviour:
- Address split: offset = addr[1:0]; index = addr[4:2]; tag = addr[15:5] (11 bits). Widths derive from the parameters.
- Storage: NUM_LINES x LINE_WORDS data words, plus a tag and valid bit per line.
- Reset (synchronous, reset=1 at rising edge):
  - state=IDLE; all valid=0; fill counter=0; hit_count=0; miss_count=0.
  - mem_read=0; mem_address=0; cpu_data=0; cpu_ready=0 while reset is high.
- State IDLE:
  - hit = cpu_read & valid[index] & tag match & !invalidate.
  - cpu_ready = hit (combinational); cpu_data = stored word when hit, else 0.
  - cpu_read=0: cpu_ready=0; no state change.
  - Miss (cpu_read=1, no hit, invalidate=0): latch miss tag and index; counter=0; miss_count+1; next state FILL.
- State FILL:
  - mem_read=1; mem_address = {miss_tag, miss_index, counter}; cpu_ready=0.
  - mem_valid=1: write mem_rdata to data[miss_index][counter]; counter+1.
  - Counter wraps at LINE_WORDS-1. On that write, set tag and valid, and return to IDLE the next cycle.
  - mem_valid=0: hold counter and address; unbounded wait.
  - mem_valid in IDLE is ignored.
- Latency:
  - Hit: 0 cycles.
  - Miss detected at cycle t, memory returning one word per cycle: FILL occupies t+1..t+4; hit at t+5.
- The fill is not abortable by the CPU:
  - cpu_read dropping during FILL does not stop it.
  - A changed cpu_address during FILL is ignored; it is looked up in IDLE after the fill.
- Invalidate:
  - Any state: all valid bits=0 at next edge; state=IDLE; any fill in progress is aborted and the partial line stays invalid.
  - cpu_ready=0 in the invalidate cycle.
  - Invalidate beats a simultaneous miss; no miss is counted.
- Counters:
  - hit_count increments in every cycle where cpu_ready=1.
  - miss_count increments once per IDLE to FILL transition.
  - Both saturate at 16'hFFFF.
- Reset mid-fill: behaves as full reset; the partial line is discarded.
- Conflict: a new fill overwrites the line at its index regardless of the previous valid or tag.

Decomposition:
- Shared package: WORD_SIZE; derived OFFSET_W / INDEX_W / TAG_W constants; state encoding IDLE=0, FILL=1.
- One sub-module, icache_tag_data_array:
  - Holds tag/valid/data storage.
  - Combinational read port (index, offset) returning word, tag, valid.
  - Synchronous word-write port, line-commit port (tag + valid set), and global valid clear.
- icache_fill_unit keeps the FSM, fill counter, hit compare and counters.

Test Plan:
- Cold miss: reset, cpu_read=1, cpu_address=16'h0042, memory with zero wait and data = address.
  - cpu_ready=0 for 5 cycles; mem_address steps 0x0040..0x0043.
  - Then cpu_ready=1, cpu_data=0x0042; miss_count=1.
- Hits after fill: addresses 0x0040..0x0043 consecutively -> cpu_ready=1 every cycle with matching data; hit_count increments by 4; no mem_read.
- Conflict: fill 0x0042, then read 0x0062 (same index, tag differs) -> miss and refill. Then 0x0042 misses again; miss_count=3.
- Wait states: mem_valid pattern 1,0,0,1,1,0,1 during FILL -> exactly 4 writes; mem_address holds across gaps; IDLE the cycle after the 7th fill cycle.
- Invalidate mid-fill: assert invalidate after the 2nd fill word.
  - Next cycle: IDLE, mem_read=0.
  - Re-requesting the same address misses and refetches all 4 words.
- Reset mid-fill and saturation:
  - reset during FILL -> counters 0, mem_read=0, previously valid line misses.
  - Force hit_count to 16'hFFFF, then hit -> stays 16'hFFFF.
